// File: rtl/adc128_spi_reader.sv
// SPI front-end for an ADC128S022-class converter: round-robin channel scan,
// frame sequencing from external SCLK edge enables, single-entry result register.
//
// state  | meaning
// IDLE   | CS high; waiting for an NE event with enable=1 to start a frame
// ACTIVE | CS low; toggling SCLK on NE/PE events and shifting 16 bits
module adc128_spi_reader #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk_clk,
  input  logic              reset_n,
  input  logic              pe_sclk,
  input  logic              ne_sclk_n,
  input  logic              enable,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              adc_din,
  input  logic              adc_dout,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_chan,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [2:0]        addr, addr_nxt;
  logic [15:0]       shift, shift_nxt;
  logic [2:0]        next_chan, next_chan_nxt;
  logic [2:0]        prev_addr, prev_addr_nxt;
  logic              cs_n_nxt, sclk_nxt, din_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [2:0]        chan_nxt;
  logic              valid_nxt, overrun_nxt;
  logic              pe_ev, ne_ev, din_bit, frame_end;

  // A coincident PE suppresses the NE event
  assign pe_ev = pe_sclk;
  assign ne_ev = ~ne_sclk_n & ~pe_sclk;

  always_comb begin
    case (bit_cnt)
      4'd2:    din_bit = addr[2];
      4'd3:    din_bit = addr[1];
      4'd4:    din_bit = addr[0];
      default: din_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    cs_n_nxt      = adc_cs_n;
    sclk_nxt      = adc_sclk;
    din_nxt       = adc_din;
    bit_cnt_nxt   = bit_cnt;
    addr_nxt      = addr;
    shift_nxt     = shift;
    next_chan_nxt = next_chan;
    prev_addr_nxt = prev_addr;
    data_nxt      = sample_data;
    chan_nxt      = sample_chan;
    valid_nxt     = sample_valid;
    overrun_nxt   = 1'b0;
    frame_end     = 1'b0;

    case (state)
      IDLE: begin
        if (ne_ev && enable) begin
          cs_n_nxt    = 1'b0;
          bit_cnt_nxt = 4'd0;
          addr_nxt    = next_chan;
          state_nxt   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ne_ev && adc_sclk) begin
          sclk_nxt = 1'b0;
          din_nxt  = din_bit;
        end else if (pe_ev && !adc_sclk) begin
          sclk_nxt    = 1'b1;
          shift_nxt   = {shift[14:0], adc_dout};
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            frame_end = 1'b1;
            cs_n_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The ADC returns the conversion of the channel addressed in the previous frame
    if (frame_end) begin
      data_nxt      = shift_nxt[DATA_W-1:0];
      chan_nxt      = prev_addr;
      prev_addr_nxt = addr;
      next_chan_nxt = (next_chan == 3'(NUM_CH - 1)) ? 3'd0 : next_chan + 3'd1;
      valid_nxt     = 1'b1;
      overrun_nxt   = sample_valid & ~sample_ready;
    end else if (sample_valid && sample_ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      adc_din      <= 1'b0;
      bit_cnt      <= 4'd0;
      addr         <= 3'd0;
      shift        <= 16'd0;
      next_chan    <= 3'd0;
      prev_addr    <= 3'd0;
      sample_data  <= '0;
      sample_chan  <= 3'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      adc_cs_n     <= cs_n_nxt;
      adc_sclk     <= sclk_nxt;
      adc_din      <= din_nxt;
      bit_cnt      <= bit_cnt_nxt;
      addr         <= addr_nxt;
      shift        <= shift_nxt;
      next_chan    <= next_chan_nxt;
      prev_addr    <= prev_addr_nxt;
      sample_data  <= data_nxt;
      sample_chan  <= chan_nxt;
      sample_valid <= valid_nxt;
      overrun      <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_adc128_spi_reader.sv
// Scoreboard bench for adc128_spi_reader: SCLK divider, behavioural ADC, frame monitor.
`timescale 1ns/1ps
module tb_adc128_spi_reader;

  logic        clk_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pe_sclk = 1'b0;
  logic        ne_sclk_n = 1'b1;
  logic        enable = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;
  logic [11:0] sample_data;
  logic [2:0]  sample_chan;
  logic        sample_valid, overrun;
  logic        sample_ready = 1'b0;

  adc128_spi_reader #(.NUM_CH(8), .DATA_W(12)) dut (
    .clk_clk      (clk_clk),
    .reset_n      (reset_n),
    .pe_sclk      (pe_sclk),
    .ne_sclk_n    (ne_sclk_n),
    .enable       (enable),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #10 clk_clk = ~clk_clk;

  typedef struct {
    int addr;
    int data;
    int chan;
    int ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int ready_mode = 1;   // 0: never ready, 1: always ready, 2: ready only in the frame-end cycle
  int adc_mode = 0;     // 0: constant 0xABC, 1: previously addressed channel * 0x111
  int div_cnt = 0;
  int rises = 0, falls = 0, cs_low = 0, frames_done = 0, cs_falls = 0, ovr_cnt = 0;
  int model_chan = 0;
  int ovr_base = 0, fall_base = 0;
  logic [15:0] adc_word = 16'h0;
  logic [15:0] din_word = 16'h0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, rst_q = 1'b0;

  // Frames 2..11 of the channel scan, ADC answering with channel*0x111
  int scan_addr[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int scan_chan[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int scan_data[10] = '{'h000, 'h111, 'h222, 'h333, 'h444, 'h555, 'h666, 'h777, 'h000, 'h111};

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int a, input int d, input int c, input int o);
    exp_t e;
    e.addr = a; e.data = d; e.chan = c; e.ovr = o;
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input int n);
    int budget = 0;
    int lim = (n - frames_done) * 500 + 1500;
    while (frames_done < n && budget < lim) begin
      @(negedge clk_clk);
      budget++;
    end
    chk("frame_wait", int'(frames_done >= n), 1);
  endtask

  task automatic wait_bit(input int fr, input int b);
    int budget = 0;
    while (!(frames_done == fr && !adc_cs_n && rises == b) && budget < 1500) begin
      @(negedge clk_clk);
      budget++;
    end
    chk("bit_wait", int'(budget < 1500), 1);
  endtask

  // SCLK divider: period 24, NE 13 cycles before PE; also drives sample_ready
  initial forever begin
    @(negedge clk_clk);
    div_cnt   = (div_cnt == 23) ? 0 : div_cnt + 1;
    ne_sclk_n = (div_cnt != 5);
    pe_sclk   = (div_cnt == 18);
    case (ready_mode)
      0:       sample_ready = 1'b0;
      1:       sample_ready = 1'b1;
      default: sample_ready = !adc_cs_n && !adc_sclk && rises == 15 && pe_sclk;
    endcase
  end

  always @(posedge clk_clk) rst_q = reset_n;

  // ADC model plus frame monitor; checks each completed frame against the scoreboard
  always @(negedge clk_clk) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (prev_cs && !adc_cs_n) begin
      cs_falls++;
      rises = 0; falls = 0; cs_low = 0; din_word = 16'h0;
      adc_word = (adc_mode == 0) ? 16'h0ABC : 16'(model_chan * 'h111);
    end
    if (adc_cs_n === 1'b0) cs_low++;
    if (!prev_cs && prev_sclk && !adc_sclk) begin
      if (falls < 16) adc_dout = adc_word[4'(15 - falls)];
      falls++;
    end
    if (!prev_cs && !prev_sclk && adc_sclk) begin
      if (rises < 16) din_word[4'(15 - rises)] = adc_din;
      rises++;
    end
    if (!prev_cs && adc_cs_n) begin
      model_chan = int'(din_word[13:11]);
      if (rst_q) begin
        frames_done++;
        chk("exp_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("din_addr", int'(din_word[13:11]), mon_e.addr);
          chk("frame_valid", int'(sample_valid), 1);
          chk("frame_data", int'(sample_data), mon_e.data);
          chk("frame_chan", int'(sample_chan), mon_e.chan);
          chk("frame_overrun", int'(overrun), mon_e.ovr);
          chk("cs_low_cycles", cs_low, 397);
          chk("sclk_pulses", falls, 16);
        end
      end
    end
    prev_cs = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  initial begin
    int budget;
    repeat (3) @(negedge clk_clk);
    chk("rst_cs_n", int'(adc_cs_n), 1);
    chk("rst_sclk", int'(adc_sclk), 1);
    chk("rst_din", int'(adc_din), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_data", int'(sample_data), 0);
    chk("rst_chan", int'(sample_chan), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    @(negedge clk_clk);

    // First frame: CS falls on the first NE event, reports 0xABC on channel 0
    push_exp(0, 'hABC, 0, 0);
    enable = 1'b1;
    budget = 0;
    do begin
      @(posedge clk_clk);
      budget++;
    end while (ne_sclk_n != 1'b0 && budget < 100);
    #1;
    chk("cs_fall_first_ne", int'(adc_cs_n), 0);
    chk("sclk_high_cs_setup", int'(adc_sclk), 1);
    wait_frames(1);
    adc_mode = 1;

    // Round-robin scan with wrap
    for (int i = 0; i < 10; i++) push_exp(scan_addr[i], scan_data[i], scan_chan[i], 0);
    wait_frames(11);
    repeat (3) @(negedge clk_clk);

    // Ready held low across two frames: overrun on the second only
    ready_mode = 0;
    ovr_base = ovr_cnt;
    push_exp(3, 'h222, 2, 0);
    push_exp(4, 'h333, 3, 1);
    wait_frames(13);
    repeat (3) @(negedge clk_clk);
    chk("overrun_count", ovr_cnt - ovr_base, 1);

    // Ready only in the frame-end cycle while valid is held
    ready_mode = 2;
    push_exp(5, 'h444, 4, 0);
    wait_frames(14);
    repeat (2) @(negedge clk_clk);
    chk("valid_kept", int'(sample_valid), 1);
    chk("data_kept", int'(sample_data), 'h444);
    chk("overrun_count_same", ovr_cnt - ovr_base, 1);
    ready_mode = 1;

    // enable dropped at bit 6: frame completes, no new frame until re-enabled
    push_exp(6, 'h555, 5, 0);
    wait_bit(14, 6);
    enable = 1'b0;
    wait_frames(15);
    fall_base = cs_falls;
    repeat (1000) @(negedge clk_clk);
    chk("no_cs_fall_disabled", cs_falls - fall_base, 0);
    chk("cs_idle_disabled", int'(adc_cs_n), 1);
    push_exp(7, 'h666, 6, 0);
    ready_mode = 0;
    enable = 1'b1;
    wait_frames(16);

    // One-cycle reset at bit 9 of the next frame
    adc_mode = 0;
    push_exp(0, 'hABC, 0, 0);
    wait_bit(16, 9);
    chk("valid_before_reset", int'(sample_valid), 1);
    reset_n = 1'b0;
    @(negedge clk_clk);
    reset_n = 1'b1;
    chk("midrst_cs_n", int'(adc_cs_n), 1);
    chk("midrst_sclk", int'(adc_sclk), 1);
    chk("midrst_valid", int'(sample_valid), 0);
    chk("midrst_data", int'(sample_data), 0);
    wait_frames(17);
    repeat (5) @(negedge clk_clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overrun_total", ovr_cnt - ovr_base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
